// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM stage bundle: decoded EX inputs, PC redirect, registered MEM controls
// and the data-memory store port.
interface ex_mem_stage_if #(
    parameter int DM_AW = 14
);
    logic              ex_valid;
    logic [31:0]       ex_alu_out;
    logic              ex_branch_flag;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_rs1;
    logic [31:0]       ex_rs2;
    logic [2:0]        ex_funct3;
    logic              ex_is_branch;
    logic              ex_is_jal;
    logic              ex_is_jalr;
    logic              ex_is_load;
    logic              ex_is_store;
    logic              ex_reg_write;
    logic [4:0]        ex_rd;
    logic              mem_stall;

    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              mem_valid;
    logic [31:0]       mem_wb_data;
    logic [4:0]        mem_rd;
    logic              mem_reg_write;
    logic              mem_is_load;
    logic [2:0]        mem_funct3;
    logic [3:0]        dm_web;
    logic [DM_AW-1:0]  dm_addr;
    logic [31:0]       dm_di;
    logic              misalign_err;

    modport master (
        output ex_valid, ex_alu_out, ex_branch_flag, ex_pc, ex_imm, ex_rs1, ex_rs2,
               ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_load,
               ex_is_store, ex_reg_write, ex_rd, mem_stall,
        input  redirect, redirect_pc, mem_valid, mem_wb_data, mem_rd,
               mem_reg_write, mem_is_load, mem_funct3, dm_web, dm_addr, dm_di,
               misalign_err
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_branch_flag, ex_pc, ex_imm, ex_rs1, ex_rs2,
               ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_load,
               ex_is_store, ex_reg_write, ex_rd, mem_stall,
        output redirect, redirect_pc, mem_valid, mem_wb_data, mem_rd,
               mem_reg_write, mem_is_load, mem_funct3, dm_web, dm_addr, dm_di,
               misalign_err
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: branch/jump resolution with wrong-path squash, store lane
// alignment and the EX-to-MEM pipeline register with MEM-side stall.
module ex_mem_stage #(
    parameter int SQUASH_DEPTH = 2,
    parameter int DM_AW        = 14
) (
    input logic           clk,
    input logic           rst,
    ex_mem_stage_if.slave bus
);
    logic [1:0]       sq_cnt;
    logic             live;
    logic             taken;
    logic             is_jump;
    logic [1:0]       off;
    logic [3:0]       st_web;
    logic [31:0]      st_di;
    logic             st_bad;

    logic             mem_valid_q;
    logic [31:0]      mem_wb_data_q;
    logic [4:0]       mem_rd_q;
    logic             mem_reg_write_q;
    logic             mem_is_load_q;
    logic [2:0]       mem_funct3_q;
    logic [3:0]       dm_web_q;
    logic [DM_AW-1:0] dm_addr_q;
    logic [31:0]      dm_di_q;
    logic             misalign_q;

    assign is_jump = bus.ex_is_jal | bus.ex_is_jalr;
    assign live    = bus.ex_valid & (sq_cnt == 2'd0);
    assign taken   = live & ~bus.mem_stall &
                     (is_jump | (bus.ex_is_branch & bus.ex_branch_flag));

    // Fetch consumes redirect on the same edge, so it must be quiet in reset.
    assign bus.redirect    = taken & rst;
    assign bus.redirect_pc = bus.ex_is_jalr ? ((bus.ex_rs1 + bus.ex_imm) & ~32'h1)
                                            : (bus.ex_pc + bus.ex_imm);

    assign off = bus.ex_alu_out[1:0];

    always_comb begin
        st_web = 4'hF;
        st_di  = bus.ex_rs2;
        st_bad = 1'b0;
        case (bus.ex_funct3)
            3'b000: begin
                st_web = ~(4'b0001 << off);
                st_di  = {4{bus.ex_rs2[7:0]}};
            end
            3'b001: begin
                st_di = {2{bus.ex_rs2[15:0]}};
                if (off[0]) st_bad = 1'b1;
                else        st_web = off[1] ? 4'b0011 : 4'b1100;
            end
            3'b010: begin
                if (off != 2'd0) st_bad = 1'b1;
                else             st_web = 4'h0;
            end
            default: st_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_cnt          <= 2'd0;
            mem_valid_q     <= 1'b0;
            mem_wb_data_q   <= 32'd0;
            mem_rd_q        <= 5'd0;
            mem_reg_write_q <= 1'b0;
            mem_is_load_q   <= 1'b0;
            mem_funct3_q    <= 3'd0;
            dm_web_q        <= 4'hF;
            dm_addr_q       <= '0;
            dm_di_q         <= 32'd0;
            misalign_q      <= 1'b0;
        end else if (!bus.mem_stall) begin
            if (taken)               sq_cnt <= 2'(SQUASH_DEPTH);
            else if (sq_cnt != 2'd0) sq_cnt <= sq_cnt - 2'd1;
            mem_valid_q     <= live;
            mem_wb_data_q   <= is_jump ? (bus.ex_pc + 32'd4) : bus.ex_alu_out;
            mem_rd_q        <= bus.ex_rd;
            mem_reg_write_q <= live & bus.ex_reg_write;
            mem_is_load_q   <= live & bus.ex_is_load;
            mem_funct3_q    <= bus.ex_funct3;
            dm_web_q        <= (live & bus.ex_is_store & ~st_bad) ? st_web : 4'hF;
            dm_addr_q       <= bus.ex_alu_out[DM_AW+1:2];
            dm_di_q         <= st_di;
            misalign_q      <= live & bus.ex_is_store & st_bad;
        end
    end

    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_wb_data   = mem_wb_data_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.mem_reg_write = mem_reg_write_q;
    assign bus.mem_is_load   = mem_is_load_q;
    assign bus.mem_funct3    = mem_funct3_q;
    assign bus.dm_web        = dm_web_q;
    assign bus.dm_addr       = dm_addr_q;
    assign bus.dm_di         = dm_di_q;
    assign bus.misalign_err  = misalign_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, branch squash, jalr link, store lanes,
// misaligned stores, stalled redirect and reset mid-squash.
module tb_ex_mem_stage;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ex_mem_stage_if #(.DM_AW(14)) bus ();

    ex_mem_stage #(.SQUASH_DEPTH(2), .DM_AW(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_ex();
        bus.ex_valid       = 1'b0;
        bus.ex_alu_out     = 32'd0;
        bus.ex_branch_flag = 1'b0;
        bus.ex_pc          = 32'd0;
        bus.ex_imm         = 32'd0;
        bus.ex_rs1         = 32'd0;
        bus.ex_rs2         = 32'd0;
        bus.ex_funct3      = 3'd0;
        bus.ex_is_branch   = 1'b0;
        bus.ex_is_jal      = 1'b0;
        bus.ex_is_jalr     = 1'b0;
        bus.ex_is_load     = 1'b0;
        bus.ex_is_store    = 1'b0;
        bus.ex_reg_write   = 1'b0;
        bus.ex_rd          = 5'd0;
        bus.mem_stall      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_ex();
        rst = 1'b0;
        bus.ex_valid  = 1'b1;
        bus.ex_is_jal = 1'b1;
        step();
        step();
        vectors++;
        if (bus.redirect !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_redirect: got %b want 0", bus.redirect);
        end
        vectors++;
        if ({bus.mem_valid, bus.mem_reg_write, bus.mem_is_load, bus.misalign_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.mem_valid, bus.mem_reg_write, bus.mem_is_load, bus.misalign_err});
        end
        vectors++;
        if (bus.dm_web !== 4'hF || bus.dm_addr !== 14'd0 || bus.dm_di !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_dm: got web=%h addr=%h di=%h want F/0/0",
                     bus.dm_web, bus.dm_addr, bus.dm_di);
        end
        vectors++;
        if (bus.mem_wb_data !== 32'd0 || bus.mem_rd !== 5'd0 || bus.mem_funct3 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mem: got wb=%h rd=%0d f3=%0d want 0",
                     bus.mem_wb_data, bus.mem_rd, bus.mem_funct3);
        end
        clear_ex();
        rst = 1'b1;
        step();
    endtask

    task automatic test_branch_squash();
        clear_ex();
        bus.ex_valid       = 1'b1;
        bus.ex_is_branch   = 1'b1;
        bus.ex_branch_flag = 1'b1;
        bus.ex_pc          = 32'h100;
        bus.ex_imm         = 32'h20;
        #1;
        vectors++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h120) begin
            miscompares++;
            $display("FAIL beq_redirect: got %b/%h want 1/00000120", bus.redirect, bus.redirect_pc);
        end
        step();
        vectors++;
        if (bus.mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_mem_valid: got %b want 1", bus.mem_valid);
        end
        // Wrong-path instructions look like taken branches; they must not redirect.
        for (int i = 0; i < 3; i++) begin
            clear_ex();
            bus.ex_valid       = 1'b1;
            bus.ex_is_branch   = 1'b1;
            bus.ex_branch_flag = (i < 2);
            bus.ex_alu_out     = 32'h10 + i;
            bus.ex_reg_write   = 1'b1;
            #1;
            vectors++;
            if (bus.redirect !== 1'b0) begin
                miscompares++;
                $display("FAIL squash_redirect[%0d]: got %b want 0", i, bus.redirect);
            end
            step();
            vectors++;
            if (bus.mem_valid !== (i == 2) || bus.mem_reg_write !== (i == 2)) begin
                miscompares++;
                $display("FAIL squash_mem[%0d]: got valid=%b rw=%b want %b", i,
                         bus.mem_valid, bus.mem_reg_write, (i == 2));
            end
        end
    endtask

    task automatic test_jalr();
        clear_ex();
        bus.ex_valid     = 1'b1;
        bus.ex_is_jalr   = 1'b1;
        bus.ex_rs1       = 32'h2003;
        bus.ex_imm       = 32'h4;
        bus.ex_pc        = 32'h40;
        bus.ex_rd        = 5'd1;
        bus.ex_reg_write = 1'b1;
        bus.ex_alu_out   = 32'hDEAD0000;
        #1;
        vectors++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h2006) begin
            miscompares++;
            $display("FAIL jalr_redirect: got %b/%h want 1/00002006", bus.redirect, bus.redirect_pc);
        end
        step();
        vectors++;
        if (bus.mem_wb_data !== 32'h44 || bus.mem_rd !== 5'd1 || bus.mem_reg_write !== 1'b1) begin
            miscompares++;
            $display("FAIL jalr_link: got wb=%h rd=%0d rw=%b want 00000044/1/1",
                     bus.mem_wb_data, bus.mem_rd, bus.mem_reg_write);
        end
        // Squash counter keeps draining with EX empty.
        clear_ex();
        step();
        step();
        bus.ex_valid   = 1'b1;
        bus.ex_alu_out = 32'h5;
        step();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.mem_wb_data !== 32'h5) begin
            miscompares++;
            $display("FAIL jalr_drain: got valid=%b wb=%h want 1/00000005", bus.mem_valid, bus.mem_wb_data);
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] alu_t [7];
        logic [2:0]  f3_t  [7];
        logic [31:0] rs2_t [7];
        logic [3:0]  web_t [7];
        logic [31:0] di_t  [7];
        alu_t = '{32'h1002, 32'h1002, 32'h1000, 32'h1000, 32'h1001, 32'h1003, 32'h1000};
        f3_t  = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
        rs2_t = '{32'hAB, 32'h1234, 32'h5678, 32'hDEADBEEF, 32'h11, 32'hC3, 32'h7E};
        web_t = '{4'b1011, 4'b0011, 4'b1100, 4'b0000, 4'b1101, 4'b0111, 4'b1110};
        di_t  = '{32'hABABABAB, 32'h12341234, 32'h56785678, 32'hDEADBEEF,
                  32'h11111111, 32'hC3C3C3C3, 32'h7E7E7E7E};
        for (int i = 0; i < 7; i++) begin
            clear_ex();
            bus.ex_valid    = 1'b1;
            bus.ex_is_store = 1'b1;
            bus.ex_alu_out  = alu_t[i];
            bus.ex_funct3   = f3_t[i];
            bus.ex_rs2      = rs2_t[i];
            step();
            vectors++;
            if (bus.dm_web !== web_t[i] || bus.dm_di !== di_t[i] || bus.dm_addr !== 14'h400 ||
                bus.misalign_err !== 1'b0) begin
                miscompares++;
                $display("FAIL store_lane[%0d]: got web=%b di=%h addr=%h mis=%b want %b/%h/400/0",
                         i, bus.dm_web, bus.dm_di, bus.dm_addr, bus.misalign_err, web_t[i], di_t[i]);
            end
        end
        clear_ex();
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_funct3  = 3'd2;
        bus.ex_alu_out = 32'h0000_3FFC;
        step();
        vectors++;
        if (bus.dm_web !== 4'hF || bus.dm_addr !== 14'hFFF || bus.mem_is_load !== 1'b1) begin
            miscompares++;
            $display("FAIL load: got web=%h addr=%h ld=%b want F/0FFF/1",
                     bus.dm_web, bus.dm_addr, bus.mem_is_load);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] alu_t [3];
        logic [2:0]  f3_t  [3];
        alu_t = '{32'h1001, 32'h1003, 32'h1000};
        f3_t  = '{3'd2, 3'd1, 3'd4};
        for (int i = 0; i < 3; i++) begin
            clear_ex();
            bus.ex_valid    = 1'b1;
            bus.ex_is_store = 1'b1;
            bus.ex_alu_out  = alu_t[i];
            bus.ex_funct3   = f3_t[i];
            bus.ex_rs2      = 32'hFFFF_FFFF;
            step();
            vectors++;
            if (bus.dm_web !== 4'hF || bus.misalign_err !== 1'b1 || bus.mem_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL misalign[%0d]: got web=%h mis=%b valid=%b want F/1/1",
                         i, bus.dm_web, bus.misalign_err, bus.mem_valid);
            end
            clear_ex();
            bus.ex_valid = 1'b1;
            step();
            vectors++;
            if (bus.misalign_err !== 1'b0) begin
                miscompares++;
                $display("FAIL misalign_pulse[%0d]: got %b want 0", i, bus.misalign_err);
            end
        end
    endtask

    task automatic test_stall_redirect();
        clear_ex();
        bus.ex_valid   = 1'b1;
        bus.ex_alu_out = 32'h55;
        step();
        bus.ex_alu_out     = 32'h77;
        bus.ex_is_branch   = 1'b1;
        bus.ex_branch_flag = 1'b1;
        bus.ex_pc          = 32'h200;
        bus.ex_imm         = 32'h10;
        bus.mem_stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.redirect !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_redirect[%0d]: got %b want 0", i, bus.redirect);
            end
            step();
            vectors++;
            if (bus.mem_wb_data !== 32'h55 || bus.mem_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got wb=%h valid=%b want 00000055/1",
                         i, bus.mem_wb_data, bus.mem_valid);
            end
        end
        bus.mem_stall = 1'b0;
        #1;
        vectors++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h210) begin
            miscompares++;
            $display("FAIL stall_release: got %b/%h want 1/00000210", bus.redirect, bus.redirect_pc);
        end
        step();
        vectors++;
        if (bus.mem_wb_data !== 32'h77) begin
            miscompares++;
            $display("FAIL stall_enter: got wb=%h want 00000077", bus.mem_wb_data);
        end
        for (int i = 0; i < 3; i++) begin
            clear_ex();
            bus.ex_valid = 1'b1;
            step();
            vectors++;
            if (bus.mem_valid !== (i == 2)) begin
                miscompares++;
                $display("FAIL stall_squash[%0d]: got %b want %b", i, bus.mem_valid, (i == 2));
            end
        end
    endtask

    task automatic test_reset_mid_squash();
        clear_ex();
        bus.ex_valid     = 1'b1;
        bus.ex_is_jal    = 1'b1;
        bus.ex_pc        = 32'h300;
        bus.ex_imm       = 32'h8;
        bus.ex_is_store  = 1'b1;
        bus.ex_funct3    = 3'd2;
        step();
        clear_ex();
        bus.ex_valid = 1'b1;
        step();
        // Counter is now 1; reset while a jal sits in EX.
        bus.ex_is_jal    = 1'b1;
        bus.ex_alu_out   = 32'h1234;
        bus.ex_reg_write = 1'b1;
        rst = 1'b0;
        step();
        vectors++;
        if (bus.redirect !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_redirect: got %b want 0", bus.redirect);
        end
        vectors++;
        if (bus.mem_valid !== 1'b0 || bus.mem_reg_write !== 1'b0 || bus.mem_wb_data !== 32'd0 ||
            bus.dm_web !== 4'hF || bus.dm_addr !== 14'd0 || bus.dm_di !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_state: got valid=%b rw=%b wb=%h web=%h addr=%h di=%h want 0/0/0/F/0/0",
                     bus.mem_valid, bus.mem_reg_write, bus.mem_wb_data, bus.dm_web, bus.dm_addr, bus.dm_di);
        end
        rst = 1'b1;
        clear_ex();
        bus.ex_valid   = 1'b1;
        bus.ex_alu_out = 32'h99;
        step();
        vectors++;
        if (bus.mem_valid !== 1'b1 || bus.mem_wb_data !== 32'h99) begin
            miscompares++;
            $display("FAIL rst_mid_live: got valid=%b wb=%h want 1/00000099", bus.mem_valid, bus.mem_wb_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear_ex();
        test_reset();
        test_branch_squash();
        test_jalr();
        test_store_lanes();
        test_misalign();
        test_stall_redirect();
        test_reset_mid_squash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
